// File: rtl/pkt_dispatch_rx_pkg.sv
// Shared definitions for the packet dispatcher: FSM state encoding, error
// codes, default framing byte, UART timing and a buffer index-width helper.
package pkt_dispatch_rx_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_LEN   = 3'd2,
    S_DATA  = 3'd3,
    S_CRC   = 3'd4,
    S_DRAIN = 3'd5
  } state_t;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_CRC  = 3'd1;
  localparam logic [2:0] ERR_ADDR = 3'd2;
  localparam logic [2:0] ERR_LEN  = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;
  localparam logic [2:0] ERR_OVR  = 3'd5;

  localparam logic [7:0] DEFAULT_PREFIX = 8'hDD;

  // 46.08 MHz / 115200 baud; one 10-bit UART character is ~4000 clocks.
  localparam int unsigned CLKS_PER_BIT  = 400;
  localparam int unsigned CLKS_PER_BYTE = 10 * CLKS_PER_BIT;

  // Address width needed to index 'depth' entries (at least 1 bit).
  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pkt_dispatch_rx_buf.sv
// pkt_buf: byte buffer with one write port and a registered read port.
// Ports:
//   clk      clock
//   we       write enable
//   wr_ptr   write address
//   wr_data  write byte
//   rd_ptr   read address (rd_data shows mem[rd_ptr] one clock later)
//   rd_data  registered read byte
module pkt_buf
  import pkt_dispatch_rx_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] wr_ptr,
  input  logic [7:0]    wr_data,
  input  logic [IW-1:0] rd_ptr,
  output logic [7:0]    rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= wr_data;
    rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/pkt_dispatch_rx.sv
// pkt_dispatch_rx: frames PREFIX, ADDR, LEN, payload[LEN], CRC packets from a
// UART byte stream, buffers the payload, validates it and drains it to one of
// N_DEST destinations over a shared data bus with a one-hot valid.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rx_data/valid   received byte and its one-cycle strobe
//   out_data        payload byte to the selected destination
//   out_valid       one-hot destination valid
//   out_last        final payload byte marker
//   out_ready       shared sink ready
//   pkt_ok/pkt_err  one-cycle accept/drop pulses; err_code qualifies pkt_err
//   busy            high whenever a packet is in progress
module pkt_dispatch_rx
  import pkt_dispatch_rx_pkg::*;
#(
  parameter logic [7:0]  PREFIX      = DEFAULT_PREFIX,
  parameter logic [7:0]  BASE_ADDR   = 8'h10,
  parameter int unsigned N_DEST      = 8,
  parameter int unsigned MAX_LEN     = 64,
  parameter int unsigned CRC_MODE    = 0,
  parameter int unsigned TIMEOUT_CYC = 480000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        out_data,
  output logic [N_DEST-1:0] out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic              pkt_ok,
  output logic              pkt_err,
  output logic [2:0]        err_code,
  output logic              busy
);

  localparam int unsigned PW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = idx_width(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, next_state;
  logic [7:0]    dest_q;
  logic          addr_bad_q;
  logic [7:0]    len_q;
  logic [7:0]    acc_q;
  logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [TW-1:0] tmo_cnt;
  logic          drain_live;
  logic [7:0]    rd_data;

  logic       counting, tmo_hit, len_over, crc_bad, data_done;
  logic       handshake, last_byte;
  logic       ok_set, err_set;
  logic [2:0] err_val;

  assign counting  = (state == S_ADDR) || (state == S_LEN) ||
                     (state == S_DATA) || (state == S_CRC);
  assign tmo_hit   = counting && !rx_valid && (tmo_cnt == TW'(TIMEOUT_CYC - 1));
  assign len_over  = rx_data > 8'(MAX_LEN);
  assign crc_bad   = (CRC_MODE == 1) && (rx_data != acc_q);
  assign data_done = 8'(wr_ptr) == (len_q - 8'd1);
  assign last_byte = 8'(rd_ptr) == (len_q - 8'd1);
  // drain_live lags entry to DRAIN by one clock, so the first byte appears
  // the cycle after the pkt_ok pulse.
  assign handshake = drain_live && out_ready;
  // Read address is looked ahead so the registered buffer output already
  // holds buf[rd_ptr] in the cycle after each handshake.
  assign rd_next   = handshake ? rd_ptr + 1'b1 : rd_ptr;
  assign busy      = (state != S_IDLE);

  pkt_buf #(
    .DEPTH (MAX_LEN)
  ) u_buf (
    .clk     (clk),
    .we      (state == S_DATA && rx_valid),
    .wr_ptr  (wr_ptr[IW-1:0]),
    .wr_data (rx_data),
    .rd_ptr  (rd_next[IW-1:0]),
    .rd_data (rd_data)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE:  if (rx_valid && rx_data == PREFIX) next_state = S_ADDR;
      S_ADDR: begin
        if (rx_valid)     next_state = S_LEN;
        else if (tmo_hit) next_state = S_IDLE;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (len_over)            next_state = S_IDLE;
          else if (rx_data == '0)  next_state = S_CRC;
          else                     next_state = S_DATA;
        end else if (tmo_hit) begin
          next_state = S_IDLE;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          if (data_done) next_state = S_CRC;
        end else if (tmo_hit) begin
          next_state = S_IDLE;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          if (addr_bad_q || crc_bad || len_q == '0) next_state = S_IDLE;
          else                                      next_state = S_DRAIN;
        end else if (tmo_hit) begin
          next_state = S_IDLE;
        end
      end
      S_DRAIN: if (handshake && last_byte) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output decode: status pulse sources and destination select
  always_comb begin
    ok_set  = 1'b0;
    err_set = 1'b0;
    err_val = ERR_NONE;
    unique case (state)
      S_LEN: begin
        if (rx_valid && len_over) begin
          err_set = 1'b1;
          err_val = ERR_LEN;
        end
      end
      S_CRC: begin
        if (rx_valid) begin
          if (addr_bad_q) begin
            err_set = 1'b1;
            err_val = ERR_ADDR;
          end else if (crc_bad) begin
            err_set = 1'b1;
            err_val = ERR_CRC;
          end else begin
            ok_set = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (rx_valid) begin
          err_set = 1'b1;
          err_val = ERR_OVR;
        end
      end
      default: ;
    endcase
    if (tmo_hit) begin
      err_set = 1'b1;
      err_val = ERR_TMO;
    end

    for (int unsigned d = 0; d < N_DEST; d++) begin
      out_valid[d] = drain_live && (dest_q == 8'(d));
    end
    out_data = drain_live ? rd_data : '0;
    out_last = drain_live && last_byte;
  end

  // Datapath and registered status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dest_q     <= '0;
      addr_bad_q <= 1'b0;
      len_q      <= '0;
      acc_q      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tmo_cnt    <= '0;
      drain_live <= 1'b0;
      pkt_ok     <= 1'b0;
      pkt_err    <= 1'b0;
      err_code   <= '0;
    end else begin
      if (rx_valid) begin
        unique case (state)
          S_IDLE: begin
            if (rx_data == PREFIX) begin
              wr_ptr <= '0;
              rd_ptr <= '0;
              acc_q  <= '0;
            end
          end
          S_ADDR: begin
            dest_q     <= rx_data - BASE_ADDR;
            addr_bad_q <= (rx_data < BASE_ADDR) ||
                          ((rx_data - BASE_ADDR) >= 8'(N_DEST));
            acc_q      <= rx_data;
          end
          S_LEN: begin
            len_q <= rx_data;
            acc_q <= acc_q ^ rx_data;
          end
          S_DATA: begin
            wr_ptr <= wr_ptr + 1'b1;
            acc_q  <= acc_q ^ rx_data;
          end
          default: ;
        endcase
      end

      if (handshake) rd_ptr <= rd_ptr + 1'b1;

      if (!counting || rx_valid || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;

      drain_live <= (state == S_DRAIN) && (next_state == S_DRAIN);
      pkt_ok     <= ok_set;
      pkt_err    <= err_set;
      err_code   <= err_set ? err_val : ERR_NONE;
    end
  end

endmodule

// File: tb/tb_pkt_dispatch_rx.sv
module tb_pkt_dispatch_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] out_data;
  logic [7:0] out_valid;
  logic       out_last;
  logic       out_ready = 1'b0;
  logic       pkt_ok;
  logic       pkt_err;
  logic [2:0] err_code;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int ov_cnt = 0;

  pkt_dispatch_rx #(
    .PREFIX      (8'hDD),
    .BASE_ADDR   (8'h10),
    .N_DEST      (8),
    .MAX_LEN     (64),
    .CRC_MODE    (1),
    .TIMEOUT_CYC (200)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pkt_ok    (pkt_ok),
    .pkt_err   (pkt_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Event counters, sampled 1ns after each rising edge.
  always @(posedge clk) begin
    #1;
    if (pkt_ok)          ok_cnt++;
    if (pkt_err)         err_cnt++;
    if (out_valid != '0) ov_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the consuming edge.
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Sends n bytes, first byte in the most significant occupied position.
  task automatic send_seq(input logic [127:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      idle(2);
      send_byte(v[8*(n-1-i) +: 8]);
    end
  endtask

  // Collects n drained bytes (out_ready must be high) and checks each one.
  task automatic collect(input string name, input int n, input logic [7:0] vmask,
                         input logic [127:0] ev);
    int got = 0;
    int budget = 0;
    logic [7:0] eb;
    logic el;
    while (got < n && budget < 40) begin
      if (out_valid != '0) begin
        eb = ev[8*(n-1-got) +: 8];
        el = (got == n - 1);
        checks++;
        if (out_valid !== vmask || out_data !== eb || out_last !== el) begin
          errors++;
          $display("FAIL %s byte%0d got valid=%h data=%h last=%b want valid=%h data=%h last=%b",
                   name, got, out_valid, out_data, out_last, vmask, eb, el);
        end
        got++;
      end
      if (got < n) @(negedge clk);
      budget++;
    end
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count got %0d want %0d", name, got, n);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_end got valid=%h busy=%b want valid=00 busy=0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    checks++;
    if ({out_data, out_valid, out_last, pkt_ok, pkt_err, err_code, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got data=%h valid=%h last=%b ok=%b err=%b code=%0d busy=%b want all 0",
               out_data, out_valid, out_last, pkt_ok, pkt_err, err_code, busy);
    end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_accept();
    int e0;
    out_ready = 1'b1;
    e0 = err_cnt;
    send_seq(128'hDD14021_61D1D, 6);
    checks++;
    if (pkt_ok !== 1'b1 || pkt_err !== 1'b0) begin
      errors++;
      $display("FAIL accept_ok got ok=%b err=%b want ok=1 err=0", pkt_ok, pkt_err);
    end
    collect("accept", 2, 8'h10, 128'h161D);
    checks++;
    if (err_cnt != e0) begin
      errors++;
      $display("FAIL accept_no_err got %0d err pulses want 0", err_cnt - e0);
    end
  endtask

  task automatic test_bad_crc();
    int o0;
    o0 = ov_cnt;
    send_seq(128'hDD1501A0CC, 5);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd1 || pkt_ok !== 1'b0) begin
      errors++;
      $display("FAIL bad_crc got err=%b code=%0d ok=%b want err=1 code=1 ok=0", pkt_err, err_code, pkt_ok);
    end
    idle(5);
    checks++;
    if (ov_cnt != o0) begin
      errors++;
      $display("FAIL bad_crc_no_out got %0d valid cycles want 0", ov_cnt - o0);
    end
    send_seq(128'hDD1501A0B4, 5);
    checks++;
    if (pkt_ok !== 1'b1) begin
      errors++;
      $display("FAIL recover_ok got %b want 1", pkt_ok);
    end
    collect("recover", 1, 8'h20, 128'hA0);
  endtask

  task automatic test_bad_addr();
    int o0;
    o0 = ov_cnt;
    send_seq(128'hDD180155, 4);
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bad_addr_early got err=%b busy=%b want err=0 busy=1", pkt_err, busy);
    end
    send_seq(128'h4C, 1);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd2) begin
      errors++;
      $display("FAIL bad_addr got err=%b code=%0d want err=1 code=2", pkt_err, err_code);
    end
    idle(5);
    checks++;
    if (ov_cnt != o0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_quiet got %0d valid cycles busy=%b want 0 busy=0", ov_cnt - o0, busy);
    end
  endtask

  task automatic test_bad_len();
    send_seq(128'hDD1641, 3);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bad_len got err=%b code=%0d busy=%b want err=1 code=3 busy=0", pkt_err, err_code, busy);
    end
    send_seq(128'hDD16017760, 5);
    checks++;
    if (pkt_ok !== 1'b1) begin
      errors++;
      $display("FAIL len_resync_ok got %b want 1", pkt_ok);
    end
    collect("len_resync", 1, 8'h40, 128'h77);
  endtask

  task automatic test_timeout();
    send_seq(128'hDD16, 2);
    idle(199);
    checks++;
    if (pkt_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL tmo_early got err=%b busy=%b want err=0 busy=1", pkt_err, busy);
    end
    idle(1);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo got err=%b code=%0d busy=%b want err=1 code=4 busy=0", pkt_err, err_code, busy);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    send_seq(128'hDD160C_0102030405060708090A0B0C_16, 16);
    checks++;
    if (pkt_ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_ok got %b want 1", pkt_ok);
    end
    idle(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_valid !== 8'h40 || out_data !== 8'h01 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got valid=%h data=%h last=%b want valid=40 data=01 last=0",
                 i, out_valid, out_data, out_last);
      end
      idle(1);
    end
    send_seq(128'h99, 1);
    checks++;
    if (pkt_err !== 1'b1 || err_code !== 3'd5) begin
      errors++;
      $display("FAIL overrun got err=%b code=%0d want err=1 code=5", pkt_err, err_code);
    end
    checks++;
    if (out_valid !== 8'h40 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL overrun_hold got valid=%h data=%h want valid=40 data=01", out_valid, out_data);
    end
    out_ready = 1'b1;
    collect("bp_drain", 12, 8'h40, 128'h0102030405060708090A0B0C);
  endtask

  task automatic test_reset_mid();
    int k0, e0, o0;
    out_ready = 1'b1;
    send_seq(128'hDD160C010203, 6);
    idle(1);
    rst = 1'b1;
    idle(1);
    checks++;
    if ({out_data, out_valid, out_last, pkt_ok, pkt_err, err_code, busy} !== '0) begin
      errors++;
      $display("FAIL mid_reset got data=%h valid=%h ok=%b err=%b code=%0d busy=%b want all 0",
               out_data, out_valid, pkt_ok, pkt_err, err_code, busy);
    end
    rst = 1'b0;
    idle(1);
    k0 = ok_cnt;
    e0 = err_cnt;
    o0 = ov_cnt;
    send_seq(128'h0405060708090A0B0C16, 10);
    idle(5);
    checks++;
    if (ok_cnt != k0 || err_cnt != e0 || ov_cnt != o0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ignore got ok=%0d err=%0d valid=%0d busy=%b want 0 0 0 0",
               ok_cnt - k0, err_cnt - e0, ov_cnt - o0, busy);
    end
    send_seq(128'hDD1402161D1D, 6);
    checks++;
    if (pkt_ok !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_next got %b want 1", pkt_ok);
    end
    collect("mid_reset_next", 2, 8'h10, 128'h161D);
  endtask

  initial begin
    test_reset();
    test_accept();
    test_bad_crc();
    test_bad_addr();
    test_bad_len();
    test_timeout();
    test_back_pressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
